// File: rtl/tx_scheduler.sv
// rtl/tx_scheduler.sv - round-robin scheduler sharing one serial transmitter among NUM_REQ requesters
module tx_scheduler #(
  parameter int NUM_REQ       = 4,
  parameter int GAP_CYCLES    = 16,
  parameter int START_TIMEOUT = 64
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic [NUM_REQ-1:0]         req_in,
  input  logic                       send_busy_in,
  output logic [NUM_REQ-1:0]         grant_out,
  output logic [$clog2(NUM_REQ)-1:0] sel_out,
  output logic                       send_start_out,
  output logic [NUM_REQ-1:0]         done_out,
  output logic                       timeout_out,
  output logic                       busy_out
);

  localparam int SW = $clog2(NUM_REQ);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int TW = $clog2(START_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t               state_q;
  logic [SW-1:0]        ptr_q;
  logic [SW-1:0]        sel_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic [NUM_REQ-1:0]   done_q;
  logic                 start_q;
  logic                 timeout_q;
  logic [GW-1:0]        gap_cnt_q;
  logic [TW-1:0]        tmo_cnt_q;

  logic                 pick_vld;
  logic [SW-1:0]        pick_idx;
  logic [SW-1:0]        jsel;

  // Round-robin pick: scan from farthest to nearest after ptr so the nearest set request wins
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    jsel     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      jsel = SW'((int'(ptr_q) + k) % NUM_REQ);
      if (req_in[jsel]) begin
        pick_vld = 1'b1;
        pick_idx = jsel;
      end
    end
  end

  // Frame sequencing FSM; every output is registered here
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q   <= S_IDLE;
      ptr_q     <= SW'(NUM_REQ - 1);
      sel_q     <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      start_q   <= 1'b0;
      timeout_q <= 1'b0;
      gap_cnt_q <= '0;
      tmo_cnt_q <= '0;
    end else begin
      start_q   <= 1'b0;
      done_q    <= '0;
      timeout_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pick_vld) begin
            grant_q <= NUM_REQ'(1) << pick_idx;
            sel_q   <= pick_idx;
            state_q <= S_GRANT;
          end
        end
        S_GRANT: begin
          start_q   <= 1'b1;
          tmo_cnt_q <= '0;
          state_q   <= S_START;
        end
        S_START: begin
          state_q <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (send_busy_in) begin
            state_q <= S_WAIT_DONE;
          end else if (tmo_cnt_q == TW'(START_TIMEOUT - 2)) begin
            // Pointer left alone so the same requester is retried after the gap
            timeout_q <= 1'b1;
            grant_q   <= '0;
            gap_cnt_q <= '0;
            state_q   <= S_GAP;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TW'(1);
          end
        end
        S_WAIT_DONE: begin
          if (!send_busy_in) begin
            done_q    <= grant_q;
            grant_q   <= '0;
            ptr_q     <= sel_q;
            gap_cnt_q <= '0;
            state_q   <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
            state_q <= S_IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + GW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign grant_out      = grant_q;
  assign sel_out        = sel_q;
  assign send_start_out = start_q;
  assign done_out       = done_q;
  assign timeout_out    = timeout_q;
  assign busy_out       = (state_q != S_IDLE);

endmodule
